alu_sequencer: RTL and testbench
================================

# alu_sequencer

Initiator-side controller for the registered ALU block. It accepts one operation request at a time over a valid/ready handshake and drives the ALU block's operand, selector and shift inputs. It holds those inputs stable through the ALU block's two-stage register latency, captures the registered result, and returns it over a second valid/ready handshake. It sits between the test/control logic and the registered ALU, with its ALU-side ports wired directly to that block's data1/data2/selector/shift/out.

## Interface
Parameters:
- bus_size, 4, operand and result width
- shamt_bus_size, 2, shift field is shamt_bus_size+1 bits wide (extra bit keeps shift unsigned)
- latency, 2, clock edges from ALU inputs changing to ALU out holding the matching result; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_a  in  bus_size  operand A
- req_b  in  bus_size  operand B
- req_sel  in  3  ALU operation select
- req_shamt  in  shamt_bus_size+1  shift amount
- data1  out  bus_size  to ALU data1
- data2  out  bus_size  to ALU data2
- selector  out  3  to ALU selector
- shift  out  shamt_bus_size+1  to ALU shift
- alu_out  in  bus_size  from ALU out
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer takes result
- rsp_data  out  bus_size  captured result
- op_count  out  8  completed responses, wraps 255->0
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, WAIT, RESP. The reset state is IDLE.
- IDLE:
  - req_ready=1.
  - On a rising edge with req_valid=1, register req_a/req_b/req_sel/req_shamt into data1/data2/selector/shift, load wait counter with latency, and go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements by 1 each edge while nonzero.
  - On an edge with counter==0, capture alu_out into rsp_data and go to RESP.
- RESP:
  - rsp_valid=1 and rsp_data stable.
  - On an edge with rsp_ready=1, increment op_count modulo 256 and go to IDLE.
  - With rsp_ready=0, remain in RESP indefinitely.
- data1/data2/selector/shift change only on an accepting edge. They hold their last values in all other states, including after the response completes.
- No request is accepted in WAIT or RESP, even when rsp_ready=1 in the same cycle as the response handshake. req_ready rises the cycle after the response handshake.
- req_ready, rsp_valid and busy are decoded from the state register only. There is no combinational path from req_valid or rsp_ready to any output.
- alu_out is treated as unsigned. No width extension or checking is done, and it is passed through unmodified.

## Timing
- Reset asserted, asynchronously and mid-operation:
  - state goes to IDLE and the in-flight operation is discarded with no response.
  - data1, data2, selector, shift, rsp_data, op_count and the wait counter go to 0.
  - rsp_valid=0, busy=0.
  - req_ready=1, but req_valid is ignored while reset is high.
- The accepting edge is E0. ALU inputs are valid after E0. The ALU registers them at E1, and out is valid after E0+latency. The capture edge is E0+latency+1.
- rsp_valid is high from after E0+latency+1 until the handshake edge.
- Minimum request-to-request period with rsp_ready held high is latency+3 cycles (5 at default).
- busy=1 from after E0 through the response handshake edge.
- The op_count update is visible the cycle after the handshake. The wrap from 255 to 0 is silent.

## Test plan
Bench connects alu_sequencer to the registered ALU block, or to a 2-stage registered model computing data1+data2 mod 2^bus_size, with selector=3'b000 mapped to add.
- Reset mid-WAIT: accept req_a=3, req_b=4, assert reset 1 cycle later -> rsp_valid never rises, op_count=0, data1=0, req_ready=1 after reset release; next request completes normally.
- Single add: req_a=4'h3, req_b=4'h4, sel=000, shamt=0, rsp_ready=1 -> rsp_valid rises exactly 3 cycles after the accepting edge, rsp_data=4'h7, op_count=1, req_ready high the following cycle.
- Overflow wrap: req_a=4'hF, req_b=4'h2 -> rsp_data=4'h1. Operands held on data1/data2 for every cycle of WAIT.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid rises -> rsp_data stable, req_ready=0 and a pending req_valid is not accepted; release -> handshake and IDLE next cycle.
- Back-to-back: 300 requests with req_valid always high and rsp_ready=1 -> one accept every 5 cycles, every result matches the model, op_count ends at 300 mod 256 = 44.
- latency=3 instance: single request -> rsp_valid 4 cycles after accept and the result is correct. Capturing at latency+0 must fail against the model; the bench checks the capture edge explicitly.

Source files
------------

// File: rtl/alu_sequencer.sv
// Initiator-side controller for the registered ALU block: accepts one request, holds the ALU
// inputs through the ALU pipeline latency, captures the result and returns it via valid/ready.
module alu_sequencer #(
  parameter int unsigned bus_size       = 4,
  parameter int unsigned shamt_bus_size = 2,
  parameter int unsigned latency        = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [bus_size-1:0]       req_a,
  input  logic [bus_size-1:0]       req_b,
  input  logic [2:0]                req_sel,
  input  logic [shamt_bus_size:0]   req_shamt,
  output logic [bus_size-1:0]       data1,
  output logic [bus_size-1:0]       data2,
  output logic [2:0]                selector,
  output logic [shamt_bus_size:0]   shift,
  input  logic [bus_size-1:0]       alu_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [bus_size-1:0]       rsp_data,
  output logic [7:0]                op_count,
  output logic                      busy
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam logic [3:0] LatCnt = 4'(latency);

  state_e     state_q;
  logic [3:0] wait_cnt_q;

  // ALU-side outputs only move on an accepting edge so the ALU sees stable operands throughout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      data1      <= '0;
      data2      <= '0;
      selector   <= '0;
      shift      <= '0;
      rsp_data   <= '0;
      op_count   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            data1      <= req_a;
            data2      <= req_b;
            selector   <= req_sel;
            shift      <= req_shamt;
            wait_cnt_q <= LatCnt;
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (wait_cnt_q == 4'd0) begin
            rsp_data <= alu_out;
            state_q  <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            op_count <= op_count + 8'd1;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake flags come from the state register alone: no input-to-output combinational path.
  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: drives a latency-2 and a latency-3 instance against pipelined ALU
// models, with a scoreboard on the response handshake plus cycle-accurate timing checks.
`timescale 1ns/1ps
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Latency-2 instance signals
  logic       req_valid, req_ready, rsp_valid, rsp_ready, busy;
  logic [3:0] req_a, req_b, data1, data2, alu_out, rsp_data;
  logic [2:0] req_sel, req_shamt, selector, shift;
  logic [7:0] op_count;

  // Latency-3 instance signals
  logic       r3_req_valid, r3_req_ready, r3_rsp_valid, r3_rsp_ready, r3_busy;
  logic [3:0] r3_req_a, r3_req_b, r3_data1, r3_data2, r3_alu_out, r3_rsp_data;
  logic [2:0] r3_req_sel, r3_req_shamt, r3_selector, r3_shift;
  logic [7:0] r3_op_count;

  alu_sequencer #(.bus_size(4), .shamt_bus_size(2), .latency(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_shamt(req_shamt),
    .data1(data1), .data2(data2), .selector(selector), .shift(shift),
    .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .op_count(op_count), .busy(busy)
  );

  alu_sequencer #(.bus_size(4), .shamt_bus_size(2), .latency(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req_valid(r3_req_valid), .req_ready(r3_req_ready),
    .req_a(r3_req_a), .req_b(r3_req_b), .req_sel(r3_req_sel), .req_shamt(r3_req_shamt),
    .data1(r3_data1), .data2(r3_data2), .selector(r3_selector), .shift(r3_shift),
    .alu_out(r3_alu_out),
    .rsp_valid(r3_rsp_valid), .rsp_ready(r3_rsp_ready), .rsp_data(r3_rsp_data),
    .op_count(r3_op_count), .busy(r3_busy)
  );

  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] sel);
    case (sel)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Registered ALU models: out follows inputs after `latency` edges
  logic [3:0] m2_s0, m2_s1, m3_s0, m3_s1, m3_s2;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m2_s0 <= '0; m2_s1 <= '0; m3_s0 <= '0; m3_s1 <= '0; m3_s2 <= '0;
    end else begin
      m2_s0 <= alu_f(data1, data2, selector);
      m2_s1 <= m2_s0;
      m3_s0 <= alu_f(r3_data1, r3_data2, r3_selector);
      m3_s1 <= m3_s0;
      m3_s2 <= m3_s1;
    end
  end
  assign alu_out    = m2_s1;
  assign r3_alu_out = m3_s2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected pushed on accept, popped on the response handshake
  logic [3:0] exp_q[$];
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got response %0h with no request outstanding", rsp_data);
      end else begin
        check("sb_data", 32'(rsp_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                      input logic [2:0] sh, input bit keep, output int t0);
    bit done = 1'b0;
    req_a = a; req_b = b; req_sel = sel; req_shamt = sh; req_valid = 1'b1;
    t0 = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      if (req_ready) begin
        @(posedge clk); #1;
        t0 = cyc;
        exp_q.push_back(alu_f(a, b, sel));
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!keep) req_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: req_ready low for 100 cycles, expected accept");
    end
  endtask

  task automatic wait_rsp(input logic [3:0] a, input logic [3:0] b, input int t0, output int dt);
    bit seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (rsp_valid) seen = 1'b1;
      else begin
        check("hold_data1", 32'(data1), 32'(a));
        check("hold_data2", 32'(data2), 32'(b));
        @(posedge clk); #1;
      end
    end
    dt = cyc - t0;
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rsp_timeout: rsp_valid low for 60 cycles, expected high");
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic [2:0] sh;
    logic [3:0] exp;
  } vec_t;

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[6];
    int   t0, dt, exp_ops, prev;
    bit   seen;

    vecs[0] = '{a: 4'hF, b: 4'h2, sel: 3'd0, sh: 3'd1, exp: 4'h1};
    vecs[1] = '{a: 4'h9, b: 4'h9, sel: 3'd0, sh: 3'd2, exp: 4'h2};
    vecs[2] = '{a: 4'h5, b: 4'h7, sel: 3'd1, sh: 3'd0, exp: 4'hE};
    vecs[3] = '{a: 4'hC, b: 4'hA, sel: 3'd2, sh: 3'd3, exp: 4'h8};
    vecs[4] = '{a: 4'h6, b: 4'h3, sel: 3'd3, sh: 3'd7, exp: 4'h5};
    vecs[5] = '{a: 4'h0, b: 4'h0, sel: 3'd0, sh: 3'd4, exp: 4'h0};

    req_valid = 0; req_a = 0; req_b = 0; req_sel = 0; req_shamt = 0; rsp_ready = 1;
    r3_req_valid = 0; r3_req_a = 0; r3_req_b = 0; r3_req_sel = 0; r3_req_shamt = 0;
    r3_rsp_ready = 1;
    exp_ops = 0;

    // Reset state
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data1", 32'(data1), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset mid-WAIT discards the operation
    send(4'h3, 4'h4, 3'd0, 3'd0, 1'b0, t0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_data1", 32'(data1), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    exp_q.delete();
    req_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 req_valid = 1'b0;
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    check("midrst_no_rsp", 32'(seen), 32'd0);
    check("midrst_op_count", 32'(op_count), 32'd0);
    check("midrst_ready_after", 32'(req_ready), 32'd1);

    // Single add with latency / op_count / req_ready timing
    send(4'h3, 4'h4, 3'd0, 3'd0, 1'b0, t0);
    wait_rsp(4'h3, 4'h4, t0, dt);
    check("single_lat", 32'(dt), 32'd3);
    check("single_data", 32'(rsp_data), 32'h7);
    @(posedge clk); #1;
    exp_ops++;
    check("single_op_count", 32'(op_count), 32'd1);
    check("single_req_ready", 32'(req_ready), 32'd1);
    check("single_rsp_valid", 32'(rsp_valid), 32'd0);

    // Table of vectors (incl. overflow wrap F+2 -> 1)
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].sh, 1'b0, t0);
      check("vec_selector", 32'(selector), 32'(vecs[i].sel));
      check("vec_shift", 32'(shift), 32'(vecs[i].sh));
      wait_rsp(vecs[i].a, vecs[i].b, t0, dt);
      check("vec_lat", 32'(dt), 32'd3);
      check("vec_data", 32'(rsp_data), 32'(vecs[i].exp));
      @(posedge clk); #1;
      exp_ops++;
      check("vec_op_count", 32'(op_count), 32'(exp_ops % 256));
      check("vec_hold_after", 32'(data1), 32'(vecs[i].a));
    end

    // Backpressure: response held, pending request not accepted
    rsp_ready = 1'b0;
    send(4'h8, 4'h5, 3'd0, 3'd0, 1'b0, t0);
    wait_rsp(4'h8, 4'h5, t0, dt);
    req_a = 4'h1; req_b = 4'h1; req_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_data", 32'(rsp_data), 32'hD);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_data1", 32'(data1), 32'h8);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    exp_ops++;
    check("bp_released_idle", 32'(req_ready), 32'd1);
    check("bp_op_count", 32'(op_count), 32'(exp_ops % 256));

    // Back-to-back: 300 requests, req_valid held high
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    prev = 0;
    for (int i = 0; i < 300; i++) begin
      send(4'($urandom), 4'($urandom), 3'($urandom_range(0, 3)), 3'($urandom), 1'b1, t0);
      if (i > 0) check("b2b_gap", 32'(t0 - prev), 32'd5);
      prev = t0;
    end
    req_valid = 1'b0;
    for (int k = 0; k < 20 && busy; k++) begin
      @(posedge clk); #1;
    end
    check("b2b_idle", 32'(busy), 32'd0);
    check("b2b_op_count", 32'(op_count), 32'd44);
    check("b2b_sb_drained", 32'(exp_q.size()), 32'd0);

    // Latency-3 instance: capture must be at accept + latency + 1
    for (int r = 0; r < 2; r++) begin
      r3_req_a = (r == 0) ? 4'h5 : 4'h9;
      r3_req_b = (r == 0) ? 4'h6 : 4'h4;
      r3_req_sel = 3'd0;
      r3_req_valid = 1'b1;
      check("r3_ready", 32'(r3_req_ready), 32'd1);
      @(posedge clk); #1;
      t0 = cyc;
      r3_req_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
        if (r3_rsp_valid) seen = 1'b1;
        else begin
          @(posedge clk); #1;
        end
      end
      check("r3_seen", 32'(seen), 32'd1);
      check("r3_lat", 32'(cyc - t0), 32'd4);
      check("r3_data", 32'(r3_rsp_data), (r == 0) ? 32'hB : 32'hD);
      @(posedge clk); #1;
      check("r3_op_count", 32'(r3_op_count), 32'(r + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
